pipe_stage_skid_latch: RTL

Parametrised pipeline stage register that replaces the hand-written per-field stage latches.
- Carries one packed stage payload with a valid/ready handshake, bubble (NOP) insertion, flush, and a registered-ready two-entry skid buffer.
- Sits between any two pipeline stages (fetch/decode, decode/execute, execute/memory, memory/writeback).
- Stalls propagate backward one cycle late without losing data.

---
 rtl/pipe_stage_skid_latch_if.sv | 36 +++
 rtl/pipe_stage_skid_latch.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_latch_if.sv
// Handshake bundle for one pipeline stage register:
// upstream accept side plus downstream head-of-stage side.
interface pipe_stage_skid_latch_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_nop;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_is_bubble;

  modport master (
    output in_valid,
    output in_data,
    output in_nop,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_is_bubble
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_nop,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_is_bubble
  );
endinterface

// File: rtl/pipe_stage_skid_latch.sv
// Generic pipeline stage register with bubble insertion,
// flush and an optional two-entry registered-ready skid.
module pipe_stage_skid_latch #(
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] BUBBLE_DATA = '0,
  parameter int                    SKID_EN     = 1,
  parameter int                    CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_stage_skid_latch_if.slave bus,
  output logic [CNT_WIDTH-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic                  main_bub_q, main_bub_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  skid_bub_q, skid_bub_d;
  logic                  rdy_q, rdy_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  in_fire;
  logic                  out_fire;
  logic                  out_v;
  logic [DATA_WIDTH-1:0] cap_data;

  assign out_v    = (state_q != EMPTY);
  assign cap_data = bus.in_nop ? BUBBLE_DATA : bus.in_data;
  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = out_v & bus.out_ready;

  // Skid build exposes a registered ready; otherwise pass-through.
  assign bus.in_ready = (SKID_EN != 0) ? rdy_q
                      : (~out_v | bus.out_ready);

  assign bus.out_valid     = out_v;
  assign bus.out_data      = main_q;
  assign bus.out_is_bubble = main_bub_q;
  assign bubble_cnt        = cnt_q;

  // Next-state: FIFO order, outputs always from the main entry.
  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    main_bub_d = main_bub_q;
    skid_d     = skid_q;
    skid_bub_d = skid_bub_q;
    if (flush) begin
      state_d    = EMPTY;
      main_d     = BUBBLE_DATA;
      main_bub_d = 1'b0;
      skid_d     = BUBBLE_DATA;
      skid_bub_d = 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d    = FULL;
            main_d     = cap_data;
            main_bub_d = bus.in_nop;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_d     = cap_data;
            main_bub_d = bus.in_nop;
          end else if (in_fire) begin
            state_d    = SKID;
            skid_d     = cap_data;
            skid_bub_d = bus.in_nop;
          end else if (out_fire) begin
            state_d    = EMPTY;
            main_d     = BUBBLE_DATA;
            main_bub_d = 1'b0;
          end
        end
        SKID: begin
          if (out_fire) begin
            state_d    = FULL;
            main_d     = skid_q;
            main_bub_d = skid_bub_q;
          end
        end
        default: begin
          state_d    = EMPTY;
          main_d     = BUBBLE_DATA;
          main_bub_d = 1'b0;
        end
      endcase
    end
  end

  // Ready is low only while both entries are occupied.
  always_comb begin
    rdy_d = (state_d != SKID);
  end

  // Saturating count of bubbles handed downstream.
  always_comb begin
    cnt_d = cnt_q;
    if (out_fire && main_bub_q && (cnt_q != {CNT_WIDTH{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= EMPTY;
      main_q     <= BUBBLE_DATA;
      main_bub_q <= 1'b0;
      skid_q     <= BUBBLE_DATA;
      skid_bub_q <= 1'b0;
      rdy_q      <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      main_bub_q <= main_bub_d;
      skid_q     <= skid_d;
      skid_bub_q <= skid_bub_d;
      rdy_q      <= rdy_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
